adns3080_spi_responder: RTL

SPI-slave emulator of the ADNS-3080 optical-flow sensor register interface, answering the same mode-3 protocol our `adns3080_Driver`/`SPI_module` pair initiates. It sits in the FPGA fabric (or a loopback test top) in place of the physical sensor. It accumulates motion samples from an internal source and serves them over SPI through single-register reads, writes and Motion_Burst. All SPI pins are oversampled by CLK, so no SPI-clock domain exists.

---
 rtl/adns3080_spi_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/adns3080_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adns3080_spi_responder
// Purpose  : SPI-slave (mode 3) emulation of the ADNS-3080 register file.
//            Accumulates motion samples from an internal source. Serves them
//            through single-register reads, writes and Motion_Burst (0x50).
//            All SPI pins are oversampled by CLK, so no SCK clock domain.
// Ports    : CLK, RSTn        system clock, async active-low reset
//            SCK, MOSI, CSN   SPI from master (CPOL=1, CPHA=1)
//            SRST             sensor reset pin, active high, acts like RSTn
//            MISO             slave data, 1 while deselected or idle
//            dx_in, dy_in     signed motion sample, taken on motion_vld
//            squal_in         surface quality latched with each sample
//            motion_vld       one-cycle sample strobe
//            cfg_bits         Configuration_bits register (0x0A)
//            wr_stb           one-cycle pulse on each committed write
//            wr_addr, wr_data address/data of the last committed write
// Revision : 1.0 - initial release
// ============================================================================
module adns3080_spi_responder #(
    parameter logic [7:0] PRODUCT_ID  = 8'h17,
    parameter logic [7:0] REVISION_ID = 8'h01,
    parameter logic [7:0] MAX_PIXEL   = 8'h3F
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       CSN,
    input  logic       SRST,
    output logic       MISO,
    input  logic [7:0] dx_in,
    input  logic [7:0] dy_in,
    input  logic [7:0] squal_in,
    input  logic       motion_vld,
    output logic [7:0] cfg_bits,
    output logic       wr_stb,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_BURST = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] c_CFG_RESET  = 8'h09;
    localparam logic [6:0] c_ADDR_MOT   = 7'h02;
    localparam logic [6:0] c_ADDR_CFG   = 7'h0A;
    localparam logic [6:0] c_ADDR_BURST = 7'h50;

    // ------------------------------------------------------------------
    // Pin synchronizers (only RSTn clears them, so SRST itself is seen)
    // ------------------------------------------------------------------
    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_csn_meta, r_csn_sync, r_csn_prev;
    logic r_srst_meta, r_srst_sync;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sck_meta  <= 1'b1;
            r_sck_sync  <= 1'b1;
            r_sck_prev  <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_csn_meta  <= 1'b1;
            r_csn_sync  <= 1'b1;
            r_csn_prev  <= 1'b1;
            r_srst_meta <= 1'b0;
            r_srst_sync <= 1'b0;
        end else begin
            r_sck_meta  <= SCK;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_mosi_meta <= MOSI;
            r_mosi_sync <= r_mosi_meta;
            r_csn_meta  <= CSN;
            r_csn_sync  <= r_csn_meta;
            r_csn_prev  <= r_csn_sync;
            r_srst_meta <= SRST;
            r_srst_sync <= r_srst_meta;
        end
    end

    logic w_sck_rise, w_sck_fall, w_csn_fall;
    assign w_sck_rise = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync & r_sck_prev;
    assign w_csn_fall = ~r_csn_sync & r_csn_prev;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t     r_state, w_state_next;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;       // MSB of the byte in flight is never needed
    logic [6:0] r_addr;        // pending write address
    logic [7:0] r_tx_sr;
    logic [2:0] r_burst_idx;   // index of the next burst byte to load
    logic       r_miso;
    logic [7:0] r_cfg;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_acc_x, r_acc_y, r_shad_x, r_shad_y, r_squal;
    logic       r_mot, r_ovf;

    // Complete byte as of the current SCK rise (old 7 bits + new MOSI bit)
    logic [7:0] w_byte;
    assign w_byte = {r_shift, r_mosi_sync};

    logic w_mot_flag;
    logic [7:0] w_motion_byte;
    assign w_mot_flag    = r_mot | (|r_acc_x) | (|r_acc_y);
    assign w_motion_byte = {w_mot_flag, 2'b00, r_ovf, 3'b000, r_cfg[4]};

    // ------------------------------------------------------------------
    // Next-state and event decode
    // ------------------------------------------------------------------
    logic w_last_rise;
    logic w_addr_done, w_rd_load, w_snapshot, w_commit, w_burst_next;

    always_comb begin
        w_state_next = r_state;
        w_last_rise  = w_sck_rise & (r_bit_cnt == 3'd7) & ~r_csn_sync;
        w_addr_done  = 1'b0;
        w_rd_load    = 1'b0;
        w_snapshot   = 1'b0;
        w_commit     = 1'b0;
        w_burst_next = 1'b0;

        if (r_csn_sync) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) w_state_next = ST_ADDR;
                end
                ST_ADDR: begin
                    if (w_last_rise) begin
                        w_addr_done = 1'b1;
                        if (w_byte[7]) begin
                            w_state_next = ST_WDATA;
                        end else begin
                            w_rd_load    = 1'b1;
                            w_snapshot   = (w_byte[6:0] == c_ADDR_MOT) ||
                                           (w_byte[6:0] == c_ADDR_BURST);
                            w_state_next = (w_byte[6:0] == c_ADDR_BURST) ?
                                           ST_BURST : ST_RDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_last_rise) begin
                        w_commit     = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
                // Leave only on the 8th rise so the last bit stays on MISO
                // until the master has sampled it.
                ST_RDATA: begin
                    if (w_last_rise) w_state_next = ST_DONE;
                end
                ST_BURST: begin
                    if (w_last_rise) w_burst_next = 1'b1;
                end
                ST_DONE: begin
                    w_state_next = ST_DONE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Register read mux, addressed by the byte just received
    logic [7:0] w_reg_rd;
    always_comb begin
        w_reg_rd = 8'h00;
        case (w_byte[6:0])
            7'h00:        w_reg_rd = PRODUCT_ID;
            7'h01:        w_reg_rd = REVISION_ID;
            c_ADDR_MOT:   w_reg_rd = w_motion_byte;
            7'h03:        w_reg_rd = r_shad_x;
            7'h04:        w_reg_rd = r_shad_y;
            7'h05:        w_reg_rd = r_squal;
            c_ADDR_CFG:   w_reg_rd = r_cfg;
            7'h3F:        w_reg_rd = ~PRODUCT_ID;
            default:      w_reg_rd = 8'h00;
        endcase
    end

    // Burst bytes 2..7; everything after reads zero
    logic [7:0] w_burst_rd;
    always_comb begin
        w_burst_rd = 8'h00;
        case (r_burst_idx)
            3'd1:    w_burst_rd = r_shad_x;
            3'd2:    w_burst_rd = r_shad_y;
            3'd3:    w_burst_rd = r_squal;
            3'd4:    w_burst_rd = 8'h00;
            3'd5:    w_burst_rd = 8'h20;
            3'd6:    w_burst_rd = MAX_PIXEL;
            default: w_burst_rd = 8'h00;
        endcase
    end

    // Signed 8-bit add with saturation; bit 8 of the result flags overflow
    function automatic logic [8:0] sat_add(input logic [7:0] a, input logic [7:0] d);
        logic [8:0] s;
        s = {a[7], a} + {d[7], d};
        if (s[8] != s[7]) sat_add = {1'b1, (s[8] ? 8'h80 : 8'h7F)};
        else              sat_add = {1'b0, s[7:0]};
    endfunction

    logic [8:0] w_sum_x, w_sum_y;
    assign w_sum_x = sat_add(r_acc_x, dx_in);
    assign w_sum_y = sat_add(r_acc_y, dy_in);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)            r_state <= ST_IDLE;
        else if (r_srst_sync) r_state <= ST_IDLE;
        else                  r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // SPI datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_addr      <= 7'd0;
            r_tx_sr     <= 8'h00;
            r_burst_idx <= 3'd0;
            r_miso      <= 1'b1;
            r_cfg       <= c_CFG_RESET;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'h00;
        end else if (r_srst_sync) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_addr      <= 7'd0;
            r_tx_sr     <= 8'h00;
            r_burst_idx <= 3'd0;
            r_miso      <= 1'b1;
            r_cfg       <= c_CFG_RESET;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;

            // The 3-bit counter wraps to 0 after each byte on its own
            if (r_csn_sync || (r_state == ST_IDLE)) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sck_rise && (r_state != ST_DONE)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_sck_rise && ((r_state == ST_ADDR) || (r_state == ST_WDATA))) begin
                r_shift <= w_byte[6:0];
            end

            if (w_addr_done && w_byte[7]) begin
                r_addr <= w_byte[6:0];
            end

            if (w_commit) begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_byte;
                if (r_addr == c_ADDR_CFG) r_cfg <= w_byte;
            end

            if (w_rd_load) begin
                r_tx_sr     <= (w_byte[6:0] == c_ADDR_BURST) ? w_motion_byte : w_reg_rd;
                r_burst_idx <= 3'd1;
            end else if (w_burst_next) begin
                r_tx_sr <= w_burst_rd;
                if (r_burst_idx != 3'd7) r_burst_idx <= r_burst_idx + 3'd1;
            end else if (w_sck_fall && ~r_csn_sync &&
                         ((r_state == ST_RDATA) || (r_state == ST_BURST))) begin
                r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end

            if (r_csn_sync || ((r_state != ST_RDATA) && (r_state != ST_BURST))) begin
                r_miso <= 1'b1;
            end else if (w_sck_fall) begin
                r_miso <= r_tx_sr[7];
            end
        end
    end

    // ------------------------------------------------------------------
    // Motion accumulation and snapshot
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_acc_x  <= 8'h00;
            r_acc_y  <= 8'h00;
            r_shad_x <= 8'h00;
            r_shad_y <= 8'h00;
            r_squal  <= 8'h00;
            r_mot    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_srst_sync) begin
            r_acc_x  <= 8'h00;
            r_acc_y  <= 8'h00;
            r_shad_x <= 8'h00;
            r_shad_y <= 8'h00;
            r_squal  <= 8'h00;
            r_mot    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (motion_vld) r_squal <= squal_in;

            if (w_snapshot) begin
                r_shad_x <= r_acc_x;
                r_shad_y <= r_acc_y;
                r_ovf    <= 1'b0;
                // A sample landing on the snapshot cycle starts the next
                // accumulation period instead of being lost.
                if (motion_vld) begin
                    r_acc_x <= dx_in;
                    r_acc_y <= dy_in;
                    r_mot   <= 1'b1;
                end else begin
                    r_acc_x <= 8'h00;
                    r_acc_y <= 8'h00;
                    r_mot   <= 1'b0;
                end
            end else if (motion_vld) begin
                r_acc_x <= w_sum_x[7:0];
                r_acc_y <= w_sum_y[7:0];
                r_mot   <= 1'b1;
                r_ovf   <= r_ovf | w_sum_x[8] | w_sum_y[8];
            end
        end
    end

    assign MISO     = r_miso;
    assign cfg_bits = r_cfg;
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule
`default_nettype wire
